// File: rtl/line_fill_eng_pkg.sv
// Shared cache package for the line fill/writeback engine: FSM state encoding,
// fetch command encodings, cache RAM write priorities and line-offset helpers.
package line_fill_eng_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWbRd   = 3'd1,
    StWbCap  = 3'd2,
    StWbSend = 3'd3,
    StAr     = 3'd4,
    StRd     = 3'd5,
    StDone   = 3'd6
  } fill_state_e;

  localparam logic [1:0] FETCH_FILL    = 2'b01;
  localparam logic [1:0] FETCH_WB_FILL = 2'b10;

  localparam logic [1:0] MEM_PRI_NONE = 2'b00;
  localparam logic [1:0] MEM_PRI_FILL = 2'b01;

  // Byte-offset bits inside one cache line.
  function automatic int unsigned line_off_width(input int unsigned list_width,
                                                 input int unsigned data_width);
    return $clog2(list_width * data_width / 8);
  endfunction

  // Line-offset width of the default geometry (32 words of 32 bits).
  localparam int unsigned LINE_OFF_W = line_off_width(32, 32);

endpackage

// File: rtl/line_wb_reader.sv
// Writeback sequencer: reads one victim word from the cache RAM, captures it,
// then sends it as a bus write beat. Owns the captured data word and computes
// the next state / word counter while the top FSM is in a writeback state.
module line_wb_reader
  import line_fill_eng_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [2:0]                                    i_state,
  input  logic [$clog2(list_width)-1:0]                 i_cnt,
  input  logic [$clog2(list_depth)-1:0]                 i_tag,
  input  logic [addr_width-1:0]                         i_victim_base,
  input  logic                                          i_mem_rgnt,
  input  logic [data_width-1:0]                         i_mem_rdata,
  input  logic                                          i_bus_w_ready,
  output logic                                          o_mem_ren,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] o_mem_raddr,
  output logic                                          o_bus_w_valid,
  output logic [addr_width-1:0]                         o_bus_w_addr,
  output logic [data_width-1:0]                         o_bus_w_data,
  output logic                                          o_bus_w_last,
  output logic [2:0]                                    o_next_state,
  output logic [$clog2(list_width)-1:0]                 o_cnt_next
);

  localparam int unsigned CNT_W    = $clog2(list_width);
  localparam int unsigned BYTE_SH  = $clog2(data_width / 8);

  logic [data_width-1:0] r_wdata;
  logic                  w_rd;
  logic                  w_send;
  logic                  w_last;

  assign w_rd   = (i_state == StWbRd);
  assign w_send = (i_state == StWbSend);
  assign w_last = (i_cnt == CNT_W'(list_width - 1));

  // Capture the RAM word; read data is valid the cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata <= '0;
    end else if (i_state == StWbCap) begin
      r_wdata <= i_mem_rdata;
    end
  end

  // Writeback sequencing: read -> capture -> send, one word at a time.
  always_comb begin
    o_next_state = i_state;
    o_cnt_next   = i_cnt;
    case (i_state)
      StWbRd: begin
        if (i_mem_rgnt) o_next_state = StWbCap;
      end
      StWbCap: begin
        o_next_state = StWbSend;
      end
      StWbSend: begin
        if (i_bus_w_ready) begin
          if (w_last) begin
            o_next_state = StAr;
            o_cnt_next   = '0;
          end else begin
            o_next_state = StWbRd;
            o_cnt_next   = i_cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign o_mem_ren     = w_rd;
  assign o_mem_raddr   = w_rd ? {i_tag, i_cnt} : '0;
  assign o_bus_w_valid = w_send;
  assign o_bus_w_addr  = w_send ? (i_victim_base + (addr_width'(i_cnt) << BYTE_SH)) : '0;
  assign o_bus_w_data  = w_send ? r_wdata : '0;
  assign o_bus_w_last  = w_send && w_last;

endmodule

// File: rtl/line_fill_eng.sv
// Line fill/writeback engine. Accepts a fetch from the write-path controller,
// optionally writes the victim line back to the bus, then bursts the new line
// from the bus into the cache data RAM under the allocated tag.
// Build option: LINE_FILL_LAST_CHK_EN enables bus_r_last position checking.
module line_fill_eng
  import line_fill_eng_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          i_fetch_req,
  output logic                                          o_fetch_gnt,
  input  logic [1:0]                                    i_fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                 i_fetch_tag,
  input  logic [addr_width-1:0]                         i_fetch_addr,
  input  logic [addr_width-1:0]                         i_fetch_addr_pre,
  output logic                                          o_fetch_done,
  output logic                                          o_mem_ren,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] o_mem_raddr,
  input  logic                                          i_mem_rgnt,
  input  logic [data_width-1:0]                         i_mem_rdata,
  output logic                                          o_mem_wen,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] o_mem_waddr,
  output logic [data_width-1:0]                         o_mem_wdata,
  output logic [1:0]                                    o_mem_wpri,
  input  logic                                          i_mem_wready,
  output logic                                          o_bus_ar_valid,
  input  logic                                          i_bus_ar_ready,
  output logic [addr_width-1:0]                         o_bus_ar_addr,
  input  logic                                          i_bus_r_valid,
  output logic                                          o_bus_r_ready,
  input  logic [data_width-1:0]                         i_bus_r_data,
  input  logic                                          i_bus_r_last,
  output logic                                          o_bus_w_valid,
  input  logic                                          i_bus_w_ready,
  output logic [addr_width-1:0]                         o_bus_w_addr,
  output logic [data_width-1:0]                         o_bus_w_data,
  output logic                                          o_bus_w_last,
  output logic                                          o_err
);

  localparam int unsigned TAG_W = $clog2(list_depth);
  localparam int unsigned CNT_W = $clog2(list_width);
  localparam int unsigned OFF_W = line_off_width(list_width, data_width);
  localparam logic [addr_width-1:0] OFF_MASK = addr_width'((64'd1 << OFF_W) - 64'd1);

  fill_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_cmd;
  logic [TAG_W-1:0]      r_tag;
  logic [addr_width-1:0] r_fill_base;
  logic [addr_width-1:0] r_victim_base;
  logic                  r_err;

  logic [2:0]            w_wb_state;
  logic [2:0]            w_wb_next_state;
  logic [CNT_W-1:0]      w_wb_cnt_next;
  logic                  w_rd;
  logic                  w_beat;
  logic                  w_beat_last;

  assign w_rd        = (r_state == StRd);
  assign w_beat      = w_rd && i_bus_r_valid && i_mem_wready;
  assign w_beat_last = (r_cnt == CNT_W'(list_width - 1));

  // The writeback sequencer only sees its states for a writeback command.
  assign w_wb_state = (r_cmd == FETCH_WB_FILL) ? r_state : StIdle;

  line_wb_reader #(
    .addr_width (addr_width),
    .list_depth (list_depth),
    .data_width (data_width),
    .list_width (list_width)
  ) u_wb_reader (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_state       (w_wb_state),
    .i_cnt         (r_cnt),
    .i_tag         (r_tag),
    .i_victim_base (r_victim_base),
    .i_mem_rgnt    (i_mem_rgnt),
    .i_mem_rdata   (i_mem_rdata),
    .i_bus_w_ready (i_bus_w_ready),
    .o_mem_ren     (o_mem_ren),
    .o_mem_raddr   (o_mem_raddr),
    .o_bus_w_valid (o_bus_w_valid),
    .o_bus_w_addr  (o_bus_w_addr),
    .o_bus_w_data  (o_bus_w_data),
    .o_bus_w_last  (o_bus_w_last),
    .o_next_state  (w_wb_next_state),
    .o_cnt_next    (w_wb_cnt_next)
  );

`ifndef LINE_FILL_LAST_CHK_EN
  logic w_unused_r_last;
  assign w_unused_r_last = i_bus_r_last;
`endif

  // Main FSM: request latch, writeback hand-off, burst read, completion, error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_cmd         <= '0;
      r_tag         <= '0;
      r_fill_base   <= '0;
      r_victim_base <= '0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_fetch_req) begin
            r_cmd         <= i_fetch_cmd;
            r_tag         <= i_fetch_tag;
            r_fill_base   <= i_fetch_addr & ~OFF_MASK;
            r_victim_base <= i_fetch_addr_pre & ~OFF_MASK;
            r_cnt         <= '0;
            case (i_fetch_cmd)
              FETCH_WB_FILL: r_state <= StWbRd;
              FETCH_FILL:    r_state <= StAr;
              default: begin
                r_state <= StDone;
                r_err   <= 1'b1;
              end
            endcase
          end
        end
        StWbRd, StWbCap, StWbSend: begin
          r_state <= fill_state_e'(w_wb_next_state);
          r_cnt   <= w_wb_cnt_next;
        end
        StAr: begin
          if (i_bus_ar_ready) r_state <= StRd;
        end
        StRd: begin
          if (w_beat) begin
`ifdef LINE_FILL_LAST_CHK_EN
            if (i_bus_r_last != w_beat_last) r_err <= 1'b1;
`endif
            if (w_beat_last) begin
              r_cnt   <= '0;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_fetch_gnt    = i_fetch_req && (r_state == StIdle);
  assign o_fetch_done   = (r_state == StDone);
  assign o_mem_wen      = w_rd && i_bus_r_valid;
  assign o_mem_waddr    = w_rd ? {r_tag, r_cnt} : '0;
  assign o_mem_wdata    = w_rd ? i_bus_r_data : '0;
  assign o_mem_wpri     = o_mem_wen ? MEM_PRI_FILL : MEM_PRI_NONE;
  assign o_bus_r_ready  = w_rd && i_mem_wready;
  assign o_bus_ar_valid = (r_state == StAr);
  assign o_bus_ar_addr  = (r_state == StAr) ? r_fill_base : '0;
  assign o_err          = r_err;

endmodule

// File: tb/tb_line_fill_eng.sv
// Bench for line_fill_eng: acts as cache RAM and external bus, keeps a word
// array for the RAM and an address-keyed map for external memory, and checks
// every transfer against them.
module tb_line_fill_eng;

  localparam int LD = 4;
  localparam int LW = 32;
  localparam int TW = 2;
  localparam int MW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_fetch_req, o_fetch_gnt, o_fetch_done;
  logic [1:0]    i_fetch_cmd;
  logic [TW-1:0] i_fetch_tag;
  logic [31:0]   i_fetch_addr, i_fetch_addr_pre;
  logic          o_mem_ren, i_mem_rgnt, o_mem_wen, i_mem_wready;
  logic [MW-1:0] o_mem_raddr, o_mem_waddr;
  logic [31:0]   i_mem_rdata, o_mem_wdata;
  logic [1:0]    o_mem_wpri;
  logic          o_bus_ar_valid, i_bus_ar_ready;
  logic [31:0]   o_bus_ar_addr;
  logic          i_bus_r_valid, o_bus_r_ready, i_bus_r_last;
  logic [31:0]   i_bus_r_data;
  logic          o_bus_w_valid, i_bus_w_ready, o_bus_w_last;
  logic [31:0]   o_bus_w_addr, o_bus_w_data;
  logic          o_err;

  always #5 clk = ~clk;

  line_fill_eng #(
    .addr_width (32),
    .list_depth (LD),
    .data_width (32),
    .list_width (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_fetch_req      (i_fetch_req),
    .o_fetch_gnt      (o_fetch_gnt),
    .i_fetch_cmd      (i_fetch_cmd),
    .i_fetch_tag      (i_fetch_tag),
    .i_fetch_addr     (i_fetch_addr),
    .i_fetch_addr_pre (i_fetch_addr_pre),
    .o_fetch_done     (o_fetch_done),
    .o_mem_ren        (o_mem_ren),
    .o_mem_raddr      (o_mem_raddr),
    .i_mem_rgnt       (i_mem_rgnt),
    .i_mem_rdata      (i_mem_rdata),
    .o_mem_wen        (o_mem_wen),
    .o_mem_waddr      (o_mem_waddr),
    .o_mem_wdata      (o_mem_wdata),
    .o_mem_wpri       (o_mem_wpri),
    .i_mem_wready     (i_mem_wready),
    .o_bus_ar_valid   (o_bus_ar_valid),
    .i_bus_ar_ready   (i_bus_ar_ready),
    .o_bus_ar_addr    (o_bus_ar_addr),
    .i_bus_r_valid    (i_bus_r_valid),
    .o_bus_r_ready    (o_bus_r_ready),
    .i_bus_r_data     (i_bus_r_data),
    .i_bus_r_last     (i_bus_r_last),
    .o_bus_w_valid    (o_bus_w_valid),
    .i_bus_w_ready    (i_bus_w_ready),
    .o_bus_w_addr     (o_bus_w_addr),
    .o_bus_w_data     (o_bus_w_data),
    .o_bus_w_last     (o_bus_w_last),
    .o_err            (o_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cache [LD*LW];
  logic [31:0] ext_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext_word(input logic [31:0] a);
    if (!ext_mem.exists(a)) ext_mem[a] = $urandom;
    return ext_mem[a];
  endfunction

  function automatic logic rnd();
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic outs_or();
    return |{o_fetch_gnt, o_fetch_done, o_mem_ren, o_mem_raddr, o_mem_wen, o_mem_waddr,
             o_mem_wdata, o_mem_wpri, o_bus_ar_valid, o_bus_ar_addr, o_bus_r_ready,
             o_bus_w_valid, o_bus_w_addr, o_bus_w_data, o_bus_w_last, o_err};
  endfunction

  task automatic clear_inputs();
    i_fetch_req = 0; i_fetch_cmd = 0; i_fetch_tag = 0; i_fetch_addr = 0;
    i_fetch_addr_pre = 0; i_mem_rgnt = 0; i_mem_rdata = 0; i_mem_wready = 0;
    i_bus_ar_ready = 0; i_bus_r_valid = 0; i_bus_r_data = 0; i_bus_r_last = 0;
    i_bus_w_ready = 0;
  endtask

  // One fetch: zw = zero-wait responders, stall_beat = beat at which RAM
  // stalls 5 cycles, bad_last = beat carrying a spurious r_last, abort_wb =
  // reset on first write beat, exp_lat = cycles from grant to done (-1 skip).
  task automatic run_fetch(input logic [1:0] cmd, input int tag, input logic [31:0] addr,
                           input logic [31:0] pre, input bit zw, input int stall_beat,
                           input int bad_last, input bit abort_wb, input int exp_lat);
    logic [31:0] fill_base, vic_base;
    int   wb_k, rd_k, cyc, stall_left, rd_idx;
    bit   ar_done, got_done, rd_pend, stalled, r_vld, fill_phase;
    fill_base = addr & ~32'h7F;
    vic_base  = pre & ~32'h7F;
    wb_k = 0; rd_k = 0; cyc = 0; stall_left = 0; rd_idx = 0;
    ar_done = 0; got_done = 0; rd_pend = 0; stalled = 0; r_vld = 0;
    @(negedge clk);
    clear_inputs();
    i_fetch_req = 1; i_fetch_cmd = cmd; i_fetch_tag = TW'(tag);
    i_fetch_addr = addr; i_fetch_addr_pre = pre;
    #1;
    chk("gnt", o_fetch_gnt, 1'b1);
    while (!got_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      i_fetch_req    = 0;
      i_mem_rdata    = rd_pend ? cache[rd_idx] : $urandom;
      rd_pend        = 0;
      i_mem_rgnt     = zw ? 1'b1 : rnd();
      i_bus_w_ready  = zw ? 1'b1 : rnd();
      i_bus_ar_ready = zw ? 1'b1 : rnd();
      i_mem_wready   = zw ? 1'b1 : rnd();
      fill_phase     = ar_done && (rd_k < LW);
      if (fill_phase) begin
        if (rd_k == stall_beat && !stalled) begin
          stalled = 1; stall_left = 5;
        end
        if (!r_vld) r_vld = zw ? 1'b1 : rnd();
        if (stall_left > 0) begin
          r_vld = 1; i_mem_wready = 0; stall_left--;
        end
        i_bus_r_valid = r_vld;
        i_bus_r_data  = ext_word(fill_base + 32'(4 * rd_k));
        i_bus_r_last  = (rd_k == LW - 1) ^ (rd_k == bad_last);
      end else begin
        i_bus_r_valid = 0; i_bus_r_data = $urandom; i_bus_r_last = 0;
      end
      #1;
      // RAM read side of writeback
      if (cmd != 2'b10 || wb_k == LW) chk("no_ren", o_mem_ren, 1'b0);
      if (o_mem_ren && i_mem_rgnt) begin
        chk("raddr", o_mem_raddr, 64'(tag * LW + wb_k));
        rd_pend = 1; rd_idx = tag * LW + wb_k;
      end
      // bus writeback beats
      if (o_bus_w_valid) begin
        if (abort_wb) begin
          rst_n = 0;
          #1;
          chk("abort_outs", outs_or(), 1'b0);
          clear_inputs();
          @(posedge clk);
          @(negedge clk);
          rst_n = 1;
          return;
        end
        chk("w_addr", o_bus_w_addr, vic_base + 32'(4 * wb_k));
        chk("w_data", o_bus_w_data, cache[tag * LW + wb_k]);
        chk("w_last", o_bus_w_last, wb_k == LW - 1);
        if (i_bus_w_ready) begin
          ext_mem[vic_base + 32'(4 * wb_k)] = cache[tag * LW + wb_k];
          wb_k++;
        end
      end
      // read address
      if (o_bus_ar_valid) begin
        chk("ar_addr", o_bus_ar_addr, fill_base);
        chk("ar_order", wb_k, (cmd == 2'b10) ? LW : 0);
        if (i_bus_ar_ready) ar_done = 1;
      end
      // fill beats into the RAM
      chk("mem_wen", o_mem_wen, fill_phase && i_bus_r_valid);
      chk("wpri", o_mem_wpri, (fill_phase && i_bus_r_valid) ? 2'b01 : 2'b00);
      if (fill_phase) chk("r_ready", o_bus_r_ready, i_mem_wready);
      if (fill_phase && i_bus_r_valid) begin
        chk("waddr", o_mem_waddr, 64'(tag * LW + rd_k));
        chk("wdata", o_mem_wdata, i_bus_r_data);
        if (i_mem_wready) begin
          cache[tag * LW + rd_k] = i_bus_r_data;
          rd_k++;
          r_vld = 0;
        end
      end
      if (o_fetch_done) begin
        got_done = 1;
        chk("done_wb", wb_k, (cmd == 2'b10) ? LW : 0);
        chk("done_rd", rd_k, LW);
        if (exp_lat >= 0) chk("latency", cyc, exp_lat);
      end
    end
    if (!got_done) chk("timeout", 1'b0, 1'b1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("done_pulse", o_fetch_done, 1'b0);
  endtask

  initial begin
    logic exp_last_err;
`ifdef LINE_FILL_LAST_CHK_EN
    exp_last_err = 1'b1;
`else
    exp_last_err = 1'b0;
`endif
    for (int i = 0; i < LD * LW; i++) cache[i] = $urandom;
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs_or(), 1'b0);
    @(negedge clk);
    rst_n = 1;

    // fill only, zero-wait, tag 2
    run_fetch(2'b01, 2, 32'h0000_1084, 32'h0, 1, -1, -1, 0, LW + 2);
    chk("fill_err", o_err, 1'b0);
    // writeback of tag 1 to 0x2000 then fill, zero-wait
    run_fetch(2'b10, 1, 32'h0000_3000, 32'h0000_2000, 1, -1, -1, 0, 3 * LW + LW + 2);
    chk("wb_err", o_err, 1'b0);
    // RAM write stall for 5 cycles at beat 10
    run_fetch(2'b01, 3, 32'h0000_4010, 32'h0, 1, 10, -1, 0, LW + 2 + 5);
    // early r_last on beat 10
    run_fetch(2'b01, 0, 32'h0000_5000, 32'h0, 1, -1, 10, 0, LW + 2);
    chk("last_err", o_err, exp_last_err);
    // reset while a writeback beat is on the bus
    run_fetch(2'b10, 1, 32'h0000_6000, 32'h0000_2000, 0, -1, -1, 1, -1);
    chk("post_rst_err", o_err, 1'b0);
    run_fetch(2'b01, 1, 32'h0000_6000, 32'h0, 1, -1, -1, 0, LW + 2);
    chk("post_rst_fill_err", o_err, 1'b0);

    // illegal command, held request across DONE
    @(negedge clk);
    i_fetch_req = 1; i_fetch_cmd = 2'b11; i_fetch_tag = 0;
    #1;
    chk("ill_gnt", o_fetch_gnt, 1'b1);
    @(negedge clk);
    #1;
    chk("ill_done", o_fetch_done, 1'b1);
    chk("ill_err", o_err, 1'b1);
    chk("ill_no_gnt_in_done", o_fetch_gnt, 1'b0);
    chk("ill_quiet", {o_bus_ar_valid, o_bus_w_valid, o_mem_ren, o_mem_wen}, 4'b0);
    @(negedge clk);
    #1;
    chk("ill_regnt", o_fetch_gnt, 1'b1);
    chk("ill_done_low", o_fetch_done, 1'b0);
    @(negedge clk);
    i_fetch_req = 0;
    #1;
    chk("ill_done2", o_fetch_done, 1'b1);
    @(negedge clk);
    #1;
    chk("ill_done2_low", o_fetch_done, 1'b0);

    // randomized fetches with random wait states
    for (int n = 0; n < 8; n++) begin
      logic [1:0]  cmd;
      logic [31:0] a, p;
      int          stall;
      cmd   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      a     = 32'h0000_8000 + 32'($urandom_range(0, 7) << 7) + 32'($urandom_range(0, 127));
      p     = 32'h0000_8000 + 32'($urandom_range(0, 7) << 7) + 32'($urandom_range(0, 127));
      stall = ($urandom_range(0, 1) != 0) ? $urandom_range(0, LW - 1) : -1;
      run_fetch(cmd, $urandom_range(0, LD - 1), a, p, 0, stall, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_fill_eng.md
# line_fill_eng

Line fill/writeback engine serving the write-path controller's fetch port. On a granted fetch request it optionally writes the victim line back to the external bus, then reads the new line from the bus and writes it word by word into the cache data memory under the allocated tag. It sits between `wr_ctrl` (upstream, `fetch_*` handshake) and the external memory bus and cache data RAM (downstream).

## Interface
- `addr_width`, 32: byte address width.
- `list_depth`, 4: number of cache lines (tags).
- `data_width`, 32: word width in bits.
- `list_width`, 32: words per line.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: fetch request from controller, held until granted.
- `fetch_gnt` out 1: request accepted.
- `fetch_cmd` in 2: `01` fill only; `10` writeback then fill.
- `fetch_tag` in $clog2(list_depth): target line.
- `fetch_addr` in addr_width: fill line address.
- `fetch_addr_pre` in addr_width: victim line address.
- `fetch_done` out 1: one-cycle completion pulse.
- `mem_ren` out 1: cache RAM read request for writeback.
- `mem_raddr` out $clog2(list_depth)+$clog2(list_width): read word address.
- `mem_rgnt` in 1: read accepted.
- `mem_rdata` in data_width: valid the cycle after `mem_rgnt`.
- `mem_wen` out 1: cache RAM fill write.
- `mem_waddr` out $clog2(list_depth)+$clog2(list_width): fill word address.
- `mem_wdata` out data_width: fill data.
- `mem_wpri` out 2: write priority, `2'b01` whenever `mem_wen`, else `2'b00`.
- `mem_wready` in 1: write accepted.
- `bus_ar_valid` out 1, `bus_ar_ready` in 1, `bus_ar_addr` out addr_width: read burst request.
- `bus_r_valid` in 1, `bus_r_ready` out 1, `bus_r_data` in data_width, `bus_r_last` in 1: read beats.
- `bus_w_valid` out 1, `bus_w_ready` in 1, `bus_w_addr` out addr_width, `bus_w_data` out data_width, `bus_w_last` out 1: writeback beats.
- `err` out 1: sticky protocol/command error.

## Operation
- `fetch_gnt = fetch_req && state==IDLE` (combinational). On handshake latch cmd, tag, fill and victim addresses with low $clog2(list_width*data_width/8) bits zeroed; clear word counter.
- States: IDLE, WB_RD, WB_CAP, WB_SEND, AR, RD, DONE.
- IDLE: cmd `10` -> WB_RD; `01` -> AR; `00`/`11` -> DONE with `err` set, no bus or RAM activity.
- WB_RD: `mem_ren=1`, `mem_raddr={tag,cnt}`; on `mem_rgnt` -> WB_CAP.
- WB_CAP: register `mem_rdata` -> WB_SEND.
- WB_SEND: `bus_w_valid=1`, `bus_w_addr=victim_base+cnt*(data_width/8)`, `bus_w_last=(cnt==list_width-1)`; on handshake: last -> AR with cnt cleared, else cnt+1 -> WB_RD.
- AR: `bus_ar_valid=1`, `bus_ar_addr`=fill base; on handshake -> RD.
- RD: `mem_wen=bus_r_valid`, `mem_wdata=bus_r_data`, `mem_waddr={tag,cnt}`, `bus_r_ready=mem_wready`. A beat is consumed when `bus_r_valid && mem_wready`; cnt+1; beat list_width-1 -> DONE.
- DONE: `fetch_done=1` one cycle -> IDLE.
- Counter width $clog2(list_width); wraps to 0 at line end, never exceeds list_width-1.
- `err` cleared only by reset.

## Timing
- Reset: state IDLE, counter 0, all outputs 0, latched fields 0; mid-operation reset abandons bus/RAM transfers without completion pulse.
- All bus valids held until ready; payload stable while valid && !ready.
- Minimum latency, cmd `01`, zero-wait: gnt cycle, AR 1, RD list_width, DONE 1 -> `fetch_done` list_width+2 cycles after gnt.
- Writeback adds 3 cycles/word minimum.
- `fetch_req` arriving in DONE is not granted until the following IDLE cycle.

## Configuration
- `LINE_FILL_LAST_CHK_EN` defined: `err` sets if `bus_r_last` is high on any beat other than beat list_width-1, or low on that beat; the fill still completes normally.
- Undefined: `bus_r_last` ignored; only illegal commands set `err`.

## Structure
- Shared cache package: state enum, fetch command encodings (`FETCH_FILL=2'b01`, `FETCH_WB_FILL=2'b10`), mem priority constants, line-offset width localparam.
- Sub-module: `line_wb_reader` (WB_RD/WB_CAP/WB_SEND sequencing and data register) instantiated by the top FSM.

## Test plan
- cmd `01`, tag 2, addr 0x0000_1084, zero-wait bus -> `bus_ar_addr`=0x0000_1080, 32 writes at `mem_waddr` 0x40..0x5F, `fetch_done` 34 cycles after gnt.
- cmd `10`, victim 0x2000, tag 1 -> 32 bus writes 0x2000..0x207C with RAM data of words 0x20..0x3F, `bus_w_last` only on 0x207C, then fill.
- `mem_wready` low 5 cycles mid-fill -> `bus_r_ready` low, no beat lost or duplicated, counter holds.
- cmd `11` -> `fetch_done` next cycle after gnt, `err`=1, no bus valids.
- With `LINE_FILL_LAST_CHK_EN`: `bus_r_last` on beat 10 -> `err`=1, fill still writes 32 words.
- Assert `rst_n` low during WB_SEND -> all outputs 0 immediately, next request granted cleanly.
